// File: rtl/geofence_feeder.sv
// Buffers upstream points into 7-point frames and replays each frame on the
// geofence checker's serial X/Y bus, pacing frames off the checker's valid pulse.
module geofence_feeder #(
    parameter int NPTS    = 7,
    parameter int NFRM    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_x,
    input  logic [9:0] in_y,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       gf_rst,
    input  logic       gf_valid,
    input  logic       gf_inside,
    output logic       res_valid,
    output logic       res_inside,
    output logic [7:0] frm_done,
    output logic       wdog_err
);
    localparam int DEPTH  = NPTS * NFRM;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FA_W   = $clog2(NFRM + 1);
    localparam int SIDX_W = $clog2(NPTS);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(NPTS - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t            state;
    logic [19:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [SIDX_W-1:0] wr_idx, sidx;
    logic [FA_W-1:0]   frame_avail;
    logic [WD_W-1:0]   wdog_cnt;
    logic [WD_W-1:0]   wdog_nxt;
    logic [19:0]       head;
    logic              push, pop, frm_inc, frm_dec, have_frame;

    assign in_ready   = (count < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign have_frame = (frame_avail != '0);
    assign head       = mem[rd_ptr];
    assign wdog_nxt   = wdog_cnt + WD_W'(1);

    // A frame is only started once all of its points are buffered, so pops
    // through SEND can never run the FIFO dry.
    assign frm_dec = have_frame && ((state == IDLE) || (state == WAIT && gf_valid));
    assign pop     = frm_dec || (state == SEND);
    assign frm_inc = push && (wr_idx == SIDX_LAST);

    // NOTE: the point storage has no reset; occupancy is tracked by the reset
    // pointers and count, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_x, in_y};
    end

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_idx      <= '0;
            frame_avail <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
                wr_idx <= (wr_idx == SIDX_LAST) ? '0 : wr_idx + SIDX_W'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case ({frm_inc, frm_dec})
                2'b10:   frame_avail <= frame_avail + FA_W'(1);
                2'b01:   frame_avail <= frame_avail - FA_W'(1);
                default: frame_avail <= frame_avail;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sidx       <= '0;
            wdog_cnt   <= '0;
            X          <= '0;
            Y          <= '0;
            gf_rst     <= 1'b1;
            res_valid  <= 1'b0;
            res_inside <= 1'b0;
            frm_done   <= '0;
            wdog_err   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gf_rst <= 1'b1;
                    if (have_frame) begin
                        {X, Y} <= head;
                        gf_rst <= 1'b0;
                        sidx   <= SIDX_W'(1);
                        state  <= SEND;
                    end
                end
                SEND: begin
                    {X, Y} <= head;
                    sidx   <= sidx + SIDX_W'(1);
                    if (sidx == SIDX_LAST) begin
                        wdog_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (gf_valid) begin
                        res_valid  <= 1'b1;
                        res_inside <= gf_inside;
                        frm_done   <= frm_done + 8'd1;
                        if (have_frame) begin
                            {X, Y} <= head;
                            sidx   <= SIDX_W'(1);
                            state  <= SEND;
                        end else begin
                            gf_rst <= 1'b1;
                            state  <= IDLE;
                        end
                    end else if (wdog_nxt == WD_LIMIT) begin
                        wdog_err <= 1'b1;
                        gf_rst   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_geofence_feeder.sv
// Directed self-checking bench for geofence_feeder: frame replay timing, FIFO
// full/same-cycle behaviour, watchdog, mid-frame reset and frame counter wrap.
module tb_geofence_feeder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_x = '0;
    logic [9:0] in_y = '0;
    logic [9:0] X, Y;
    logic       gf_rst;
    logic       gf_valid = 1'b0;
    logic       gf_inside = 1'b0;
    logic       res_valid, res_inside;
    logic [7:0] frm_done;
    logic       wdog_err;

    int checks = 0;
    int errors = 0;

    geofence_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .X(X), .Y(Y), .gf_rst(gf_rst),
        .gf_valid(gf_valid), .gf_inside(gf_inside), .res_valid(res_valid),
        .res_inside(res_inside), .frm_done(frm_done), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pt(input logic [9:0] x, input logic [9:0] y);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        checks++; if (gf_rst !== 1'b1) begin errors++; $display("FAIL reset_gf_rst got %b want 1", gf_rst); end
        checks++; if (X !== 10'd0 || Y !== 10'd0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", X, Y); end
        checks++; if (res_valid !== 1'b0 || res_inside !== 1'b0) begin errors++; $display("FAIL reset_res got %b%b want 00", res_valid, res_inside); end
        checks++; if (frm_done !== 8'd0 || wdog_err !== 1'b0) begin errors++; $display("FAIL reset_cnt got %0d,%b want 0,0", frm_done, wdog_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        reset = 1'b1;
        tick();
        tick();
        checks++; if (gf_rst !== 1'b1) begin errors++; $display("FAIL idle_gf_rst got %b want 1", gf_rst); end
    endtask

    task automatic test_single_frame;
        logic [9:0] fx [7];
        logic [9:0] fy [7];
        fx = '{10'd5, 10'd0, 10'd10, 10'd10, 10'd0, 10'd5, 10'd0};
        fy = '{10'd5, 10'd0, 10'd0, 10'd10, 10'd10, 10'd0, 10'd5};
        for (int i = 0; i < 7; i++) begin
            drive_pt(fx[i], fy[i]);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (gf_rst !== 1'b1) begin errors++; $display("FAIL f1_rst_early got %b want 1", gf_rst); end
        tick();
        checks++; if (gf_rst !== 1'b0) begin errors++; $display("FAIL f1_rst_fall got %b want 0", gf_rst); end
        checks++; if (X !== fx[0] || Y !== fy[0]) begin errors++; $display("FAIL f1_pt0 got %0d,%0d want %0d,%0d", X, Y, fx[0], fy[0]); end
        for (int i = 1; i < 7; i++) begin
            tick();
            checks++; if (X !== fx[i] || Y !== fy[i]) begin errors++; $display("FAIL f1_pt%0d got %0d,%0d want %0d,%0d", i, X, Y, fx[i], fy[i]); end
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL f1_no_res got %b want 0", res_valid); end
        gf_valid  = 1'b1;
        gf_inside = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b1 || res_inside !== 1'b1) begin errors++; $display("FAIL f1_res got %b%b want 11", res_valid, res_inside); end
        checks++; if (frm_done !== 8'd1) begin errors++; $display("FAIL f1_frm_done got %0d want 1", frm_done); end
        checks++; if (gf_rst !== 1'b1) begin errors++; $display("FAIL f1_rst_back got %b want 1", gf_rst); end
        // gf_valid still high but now in IDLE: must be ignored
        tick();
        gf_valid = 1'b0;
        checks++; if (res_valid !== 1'b0 || frm_done !== 8'd1) begin errors++; $display("FAIL f1_ignore got %b,%0d want 0,1", res_valid, frm_done); end
        checks++; if (res_inside !== 1'b1) begin errors++; $display("FAIL f1_held got %b want 1", res_inside); end
    endtask

    // Frames A (100+i), B (110+i), C (120+i) pushed back-to-back; FIFO fills while A waits.
    task automatic test_full_fifo;
        for (int k = 0; k < 21; k++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %b want 1", k, in_ready); end
            drive_pt(10'(100 + 10 * (k / 7) + (k % 7)), 10'(200 + 10 * (k / 7) + (k % 7)));
            tick();
        end
        drive_pt(10'd999, 10'd999);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready got %b want 0", in_ready); end
        checks++; if (X !== 10'd106 || gf_rst !== 1'b0) begin errors++; $display("FAIL full_a_last got %0d,%b want 106,0", X, gf_rst); end
        gf_valid  = 1'b1;
        gf_inside = 1'b0;
        tick();
        gf_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_inside !== 1'b0) begin errors++; $display("FAIL full_res got %b%b want 10", res_valid, res_inside); end
        checks++; if (frm_done !== 8'd2) begin errors++; $display("FAIL full_frm_done got %0d want 2", frm_done); end
        checks++; if (X !== 10'd110 || Y !== 10'd210 || gf_rst !== 1'b0) begin errors++; $display("FAIL full_b0 got %0d,%0d,%b want 110,210,0", X, Y, gf_rst); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b want 1", in_ready); end
    endtask

    // Push D0 during B's SEND (count 13), then finish C and D; D0 must not be the rejected 999.
    task automatic test_push_pop_same_cycle;
        drive_pt(10'd130, 10'd230);
        tick();
        in_valid = 1'b0;
        checks++; if (X !== 10'd111 || in_ready !== 1'b1) begin errors++; $display("FAIL pp_b1 got %0d,%b want 111,1", X, in_ready); end
        for (int i = 2; i < 7; i++) begin
            tick();
            checks++; if (X !== 10'(110 + i)) begin errors++; $display("FAIL pp_b%0d got %0d want %0d", i, X, 110 + i); end
        end
        gf_valid  = 1'b1;
        gf_inside = 1'b1;
        tick();
        gf_valid = 1'b0;
        checks++; if (res_inside !== 1'b1 || frm_done !== 8'd3 || X !== 10'd120) begin errors++; $display("FAIL pp_c0 got %b,%0d,%0d want 1,3,120", res_inside, frm_done, X); end
        for (int i = 1; i < 7; i++) begin
            tick();
            checks++; if (X !== 10'(120 + i)) begin errors++; $display("FAIL pp_c%0d got %0d want %0d", i, X, 120 + i); end
        end
        gf_valid  = 1'b1;
        gf_inside = 1'b0;
        tick();
        gf_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || frm_done !== 8'd4 || gf_rst !== 1'b1) begin errors++; $display("FAIL pp_c_res got %b,%0d,%b want 1,4,1", res_valid, frm_done, gf_rst); end
        for (int i = 1; i < 7; i++) begin
            drive_pt(10'(130 + i), 10'(230 + i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (X !== 10'd130 || Y !== 10'd230 || gf_rst !== 1'b0) begin errors++; $display("FAIL pp_d0 got %0d,%0d,%b want 130,230,0", X, Y, gf_rst); end
        for (int i = 1; i < 7; i++) begin
            tick();
            checks++; if (X !== 10'(130 + i)) begin errors++; $display("FAIL pp_d%0d got %0d want %0d", i, X, 130 + i); end
        end
    endtask

    task automatic test_watchdog;
        logic seen_res;
        seen_res = 1'b0;
        repeat (254) begin
            tick();
            if (res_valid === 1'b1) seen_res = 1'b1;
        end
        checks++; if (wdog_err !== 1'b0 || gf_rst !== 1'b0) begin errors++; $display("FAIL wd_early got %b,%b want 0,0", wdog_err, gf_rst); end
        tick();
        checks++; if (wdog_err !== 1'b1 || gf_rst !== 1'b1) begin errors++; $display("FAIL wd_fire got %b,%b want 1,1", wdog_err, gf_rst); end
        checks++; if (res_valid !== 1'b0 || seen_res !== 1'b0 || frm_done !== 8'd4) begin errors++; $display("FAIL wd_no_res got %b,%b,%0d want 0,0,4", res_valid, seen_res, frm_done); end
        for (int i = 0; i < 7; i++) begin
            drive_pt(10'(140 + i), 10'(240 + i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (X !== 10'd140 || gf_rst !== 1'b0) begin errors++; $display("FAIL wd_e0 got %0d,%b want 140,0", X, gf_rst); end
        repeat (6) tick();
        gf_valid  = 1'b1;
        gf_inside = 1'b1;
        tick();
        gf_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || frm_done !== 8'd5 || wdog_err !== 1'b1) begin errors++; $display("FAIL wd_after got %b,%0d,%b want 1,5,1", res_valid, frm_done, wdog_err); end
    endtask

    task automatic test_reset_mid_send;
        for (int k = 0; k < 10; k++) begin
            drive_pt(10'(150 + k), 10'(250 + k));
            tick();
        end
        in_valid = 1'b0;
        checks++; if (X !== 10'd152) begin errors++; $display("FAIL rs_sidx3 got %0d want 152", X); end
        reset = 1'b0;
        #1;
        checks++; if (gf_rst !== 1'b1 || X !== 10'd0 || Y !== 10'd0) begin errors++; $display("FAIL rs_async got %b,%0d,%0d want 1,0,0", gf_rst, X, Y); end
        checks++; if (frm_done !== 8'd0 || wdog_err !== 1'b0 || res_inside !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL rs_regs got %0d,%b,%b,%b want 0,0,0,0", frm_done, wdog_err, res_inside, res_valid); end
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (gf_rst !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL rs_empty got %b,%b want 1,1", gf_rst, in_ready); end
        for (int i = 0; i < 7; i++) begin
            drive_pt(10'(170 + i), 10'(270 + i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (X !== 10'd170 || Y !== 10'd270 || gf_rst !== 1'b0) begin errors++; $display("FAIL rs_h0 got %0d,%0d,%b want 170,270,0", X, Y, gf_rst); end
        for (int i = 1; i < 7; i++) begin
            tick();
            checks++; if (X !== 10'(170 + i)) begin errors++; $display("FAIL rs_h%0d got %0d want %0d", i, X, 170 + i); end
        end
    endtask

    // Frame H is already waiting; 256 results in total wrap frm_done back to 0.
    task automatic test_frm_done_wrap;
        logic exp_in;
        for (int f = 1; f <= 256; f++) begin
            if (f > 1) begin
                for (int i = 0; i < 7; i++) begin
                    drive_pt(10'(f), 10'(i));
                    tick();
                end
                in_valid = 1'b0;
                repeat (7) tick();
            end
            exp_in    = (f % 3 == 0);
            gf_valid  = 1'b1;
            gf_inside = exp_in;
            tick();
            gf_valid = 1'b0;
            checks++; if (res_valid !== 1'b1 || res_inside !== exp_in) begin errors++; $display("FAIL wrap_res_%0d got %b%b want 1%b", f, res_valid, res_inside, exp_in); end
            checks++; if (frm_done !== 8'(f)) begin errors++; $display("FAIL wrap_cnt_%0d got %0d want %0d", f, frm_done, f % 256); end
        end
        tick();
        checks++; if (frm_done !== 8'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL wrap_final got %0d,%b want 0,0", frm_done, res_valid); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_full_fifo();
        test_push_pop_same_cycle();
        test_watchdog();
        test_reset_mid_send();
        test_frm_done_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/geofence_feeder.md
Name: geofence_feeder

Overview:
- Upstream stage of the geofence checker. Accepts coordinate points over a valid/ready handshake and buffers them as frames of 7 points: the object point first, then 6 fence vertices.
- Replays each complete frame on the checker's serial X/Y bus, one point per cycle, timed to the checker's load sequence.
- Uses the checker's valid pulse to pace frames. Holds the checker in reset whenever no complete frame is ready. Includes a watchdog for a hung checker.

Parameters:
- NPTS, 7, points per frame (object + 6 vertices).
- NFRM, 2, frames of buffering; FIFO depth = NPTS*NFRM points.
- TIMEOUT, 255, maximum cycles spent in WAIT before the watchdog fires.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream point valid
- in_ready  out  1  FIFO can accept a point
- in_x  in  10  upstream point X
- in_y  in  10  upstream point Y
- X  out  10  registered X to checker
- Y  out  10  registered Y to checker
- gf_rst  out  1  active-high reset to checker (registered)
- gf_valid  in  1  checker result valid
- gf_inside  in  1  checker result
- res_valid  out  1  one-cycle pulse; result captured
- res_inside  out  1  captured result, held until next res_valid
- frm_done  out  8  completed-frame counter, wraps 255->0
- wdog_err  out  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, async):
  - FIFO empty, frame_avail=0, state IDLE.
  - gf_rst=1, X=Y=0, res_valid=0, res_inside=0, frm_done=0, wdog_err=0.
  - Reset mid-frame discards all buffered and in-flight points.
- FIFO input:
  - in_ready = (count < NPTS*NFRM), combinational from count.
  - A push occurs when in_valid && in_ready.
  - A write-side point counter wraps at NPTS. On the NPTS-th push of a frame, frame_avail increments.
- Pops and occupancy:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - frame_avail inc and dec in the same cycle cancel.
  - Pop never occurs on empty. Push never occurs on full.
- State machine, all outputs registered:
  - IDLE:
    - gf_rst=1.
    - If frame_avail>0: pop point 0 onto X/Y, gf_rst<=0, frame_avail dec, sidx<=1, go SEND.
  - SEND:
    - Each cycle, pop the next point onto X/Y and increment sidx.
    - When point NPTS-1 is driven, go WAIT and clear the watchdog counter. X/Y hold the last point.
  - WAIT, on gf_valid=1:
    - res_valid<=1, res_inside<=gf_inside, frm_done++.
    - If frame_avail>0: pop point 0 onto X/Y, frame_avail dec, sidx<=1, go SEND.
    - Else: gf_rst<=1, go IDLE.
  - WAIT, watchdog: watchdog counter increments each cycle. When it reaches TIMEOUT: wdog_err<=1, gf_rst<=1, go IDLE, no res_valid.
- Checker handshake timing:
  - Point 0 is driven on the edge where gf_valid is sampled high, or where gf_rst deasserts.
  - The checker samples the object on the following edge and vertices on the next 6 edges, so no bubbles are allowed inside SEND.
- res_valid is high for exactly one cycle per gf_valid pulse.
- gf_valid seen outside WAIT is ignored.

Test Plan:
- Reset, then push 7 points back-to-back: obj (5,5), vertices (0,0),(10,0),(10,10),(0,10),(-) ... -> gf_rst falls the edge after the 7th push. X/Y show (5,5) then the vertices on 7 consecutive cycles. Force gf_valid=1, gf_inside=1 -> res_valid pulse, res_inside=1, frm_done=1, then gf_rst=1.
- Push 14 points before any gf_valid -> in_ready=0 after the 14th push. After the first gf_valid, frame 2 obj is on X the next cycle, gf_rst stays 0, and in_ready returns to 1 as points pop.
- Push and pop in the same cycle at count=14 during SEND -> push rejected (in_ready=0). At count=13 -> count stays 13.
- Hold gf_valid=0 in WAIT for 255 cycles -> wdog_err=1, gf_rst=1, state IDLE, no res_valid. A later frame is still served.
- Assert reset during SEND at sidx=3 -> all outputs return to reset values immediately. The partial frame is gone, and the next 7 pushes form a fresh frame.
- 256 frames end-to-end -> frm_done wraps to 0. res_inside matches the injected gf_inside for every frame.
